// File: rtl/mainmem_pkg.sv
// Shared types and constants for the main memory model.
package mainmem_pkg;

  // Default geometry; the request struct is sized from these.
  localparam int MM_LINE_BYTES = 32;
  localparam int MM_ADDR_W     = 27;
  localparam int MM_LW         = 8 * MM_LINE_BYTES;

  // Latency counter width (covers latencies 1..15).
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RSP  = 2'd2,
    WR_BUSY = 2'd3
  } mainmem_state_t;

  typedef struct packed {
    logic                     write;
    logic [MM_ADDR_W-1:0]     addr;
    logic [MM_LINE_BYTES-1:0] be;
    logic [MM_LW-1:0]         wd;
  } mainmem_req_t;

endpackage

// File: rtl/mainmem_req_fifo.sv
// Request queue in front of the memory FSM. Pointers carry one extra wrap
// bit so occupancy is their difference; reset clears the pointers only.
module mainmem_req_fifo
  import mainmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  mainmem_req_t din_i,
  input  logic         pop_i,
  output mainmem_req_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wptr_q, wptr_d, rptr_q, rptr_d, count;
  mainmem_req_t mem_q [DEPTH];

  assign count   = wptr_q - rptr_q;
  assign full_o  = (count == (PW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem_q[rptr_q[PW-1:0]];

  // Pointer advance; guarded so a stray push/pop cannot corrupt occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i && !full_o) wptr_d = wptr_q + 1'b1;
    if (pop_i && !empty_o) rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mainmem_model.sv
// Cycle-accurate main memory behind the L1 fill/writeback port.
// Requests are queued and completed strictly in order by a small FSM.
// Optional: define MAINMEM_BOUNDS_CHECK_EN to flag and suppress accesses at
// or beyond ENTRIES; otherwise the address wraps on its low bits.
module mainmem_model
  import mainmem_pkg::*;
#(
  parameter int LINE_BYTES = MM_LINE_BYTES,
  parameter int ADDR_W     = MM_ADDR_W,
  parameter int ENTRIES    = 65536,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 1,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [LINE_BYTES-1:0]   req_be_i,
  input  logic [8*LINE_BYTES-1:0] req_wd_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [8*LINE_BYTES-1:0] rsp_rd_o,
  output logic                    wr_done_o,
  output logic                    err_o
);

  localparam int LW = 8 * LINE_BYTES;
  localparam int IW = $clog2(ENTRIES);

  mainmem_state_t         state_q, state_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  mainmem_req_t           push_req, head;
  logic                   full, empty, push, pop, commit, head_oob;
  logic [LW-1:0]          rd_line, rsp_q, cur_wd_q;
  logic [IW-1:0]          cur_idx_q;
  logic [LINE_BYTES-1:0]  cur_be_q;
  logic                   cur_oob_q, wr_done_q;
  logic [LW-1:0]          ram [ENTRIES];

  assign push_req    = '{write: req_write_i, addr: req_addr_i, be: req_be_i, wd: req_wd_i};
  assign push        = req_valid_i & ~full;
  assign req_ready_o = ~full;

  mainmem_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_req),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef MAINMEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] ENT_L = (ADDR_W+1)'(ENTRIES);
  assign head_oob = ({1'b0, head.addr} >= ENT_L);
`else
  logic unused_hi;
  assign head_oob  = 1'b0;
  assign unused_hi = ^head.addr[ADDR_W-1:IW];
`endif

  assign rd_line     = head_oob ? '0 : ram[head.addr[IW-1:0]];
  assign rsp_valid_o = (state_q == RD_RSP);
  assign rsp_rd_o    = rsp_valid_o ? rsp_q : '0;
  assign wr_done_o   = wr_done_q;

  // Next state: pop in IDLE, count latency down, commit writes on expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        if (head.write) begin
          state_d = WR_BUSY;
          cnt_d   = LAT_W'(WRITE_LAT - 1);
        end else begin
          state_d = RD_WAIT;
          cnt_d   = LAT_W'(READ_LAT - 1);
        end
      end
      RD_WAIT: if (cnt_q == '0) state_d = RD_RSP;
               else             cnt_d   = cnt_q - 1'b1;
      RD_RSP:  if (rsp_ready_i) state_d = IDLE;
      WR_BUSY: if (cnt_q == '0) begin
                 state_d = IDLE;
                 commit  = 1'b1;
               end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; read data is snapshotted at pop, write payload held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_q     <= '0;
      wr_done_q <= 1'b0;
      cur_idx_q <= '0;
      cur_be_q  <= '0;
      cur_wd_q  <= '0;
      cur_oob_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_done_q <= commit;
      if (pop) begin
        cur_idx_q <= head.addr[IW-1:0];
        cur_be_q  <= head.be;
        cur_wd_q  <= head.wd;
        cur_oob_q <= head_oob;
        if (!head.write) rsp_q <= rd_line;
      end
    end
  end

  // Byte-merge commit into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (commit && !cur_oob_q)
      for (int i = 0; i < LINE_BYTES; i++)
        if (cur_be_q[i]) ram[cur_idx_q][8*i +: 8] <= cur_wd_q[8*i +: 8];
  end

`ifdef MAINMEM_BOUNDS_CHECK_EN
  logic err_q;
  assign err_o = err_q;
  // Out-of-range pop: one-cycle err pulse plus a simulation message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else begin
      err_q <= pop & head_oob;
      if (pop && head_oob)
        $display("-E: access exceeds main memory size: addr 0x%0h", head.addr);
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mainmem_model.sv
// Directed/random bench for mainmem_model. Two instances: default latencies
// and READ_LAT=5/WRITE_LAT=3. Reference model is an address->line map plus
// an in-order expected-response queue. Honours MAINMEM_BOUNDS_CHECK_EN.
module tb_mainmem_model;

  localparam int LB  = 32;
  localparam int AW  = 27;
  localparam int LW  = 8 * LB;
  localparam int ENT = 65536;

  typedef struct { logic [LW-1:0] d; time t; } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, rdy0, rdy1, req_write, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [LB-1:0] req_be;
  logic [LW-1:0] req_wd, rd0, rd1;
  logic rv0, rv1, wdn0, wdn1, er0, er1;

  always #5 clk = ~clk;

  mainmem_model #(.LINE_BYTES(LB), .ADDR_W(AW), .ENTRIES(ENT), .READ_LAT(2),
                  .WRITE_LAT(1), .REQ_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(rdy0),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_be_i(req_be),
    .req_wd_i(req_wd), .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready),
    .rsp_rd_o(rd0), .wr_done_o(wdn0), .err_o(er0));

  mainmem_model #(.LINE_BYTES(LB), .ADDR_W(AW), .ENTRIES(ENT), .READ_LAT(5),
                  .WRITE_LAT(3), .REQ_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_be_i(req_be),
    .req_wd_i(req_wd), .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready),
    .rsp_rd_o(rd1), .wr_done_o(wdn1), .err_o(er1));

  int nchk = 0, nerr = 0, errcnt0 = 0;
  rsp_t got0[$], got1[$];
  time  wdt0[$], wdt1[$];
  int   ev1[$];
  logic [LW-1:0] exp0[$], exp1[$];
  logic [LW-1:0] refm [int];

  // Observe completions on the falling edge.
  always @(negedge clk) begin
    if (rv0 && rsp_ready) got0.push_back('{rd0, $time});
    if (wdn0) wdt0.push_back($time);
    if (er0) errcnt0++;
    if (rv1 && rsp_ready) begin got1.push_back('{rd1, $time}); ev1.push_back(2); end
    if (wdn1) begin wdt1.push_back($time); ev1.push_back(1); end
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit m_oob(input logic [AW-1:0] a);
`ifdef MAINMEM_BOUNDS_CHECK_EN
    return int'(a) >= ENT;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_key(input int d, input logic [AW-1:0] a);
    return d * ENT + (int'(a) % ENT);
  endfunction

  // Issue one request; the model is updated at acceptance (in-order memory).
  task automatic issue(input int d, input bit w, input logic [AW-1:0] a,
                       input logic [LB-1:0] be, input logic [LW-1:0] wd, output time tacc);
    logic [LW-1:0] old;
    int k;
    tacc = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_be = be; req_wd = wd;
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ((d == 0) ? rdy0 : rdy1) begin
        @(posedge clk);
        tacc = $time;
        #1 v0 = 1'b0; v1 = 1'b0;
        k = m_key(d, a);
        old = refm.exists(k) ? refm[k] : '0;
        if (w) begin
          if (!m_oob(a))
            for (int b = 0; b < LB; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
          refm[k] = old;
        end else begin
          if (m_oob(a)) old = '0;
          if (d == 0) exp0.push_back(old); else exp1.push_back(old);
        end
        return;
      end
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("accept_timeout", LW'(0), LW'(1));
  endtask

  task automatic get_rsp(input int d, input string tag, output time t);
    logic [LW-1:0] e;
    t = 0;
    for (int i = 0; i < 200; i++) begin
      if (d == 0 && got0.size() > 0) begin
        e = exp0.pop_front(); t = got0[0].t;
        chk(tag, got0[0].d, e); got0.delete(0); return;
      end
      if (d == 1 && got1.size() > 0) begin
        e = exp1.pop_front(); t = got1[0].t;
        chk(tag, got1[0].d, e); got1.delete(0); return;
      end
      @(negedge clk);
    end
    chk({tag, "_timeout"}, LW'(0), LW'(1));
  endtask

  task automatic get_wr(input int d, output time t);
    t = 0;
    for (int i = 0; i < 200; i++) begin
      if (d == 0 && wdt0.size() > 0) begin t = wdt0.pop_front(); return; end
      if (d == 1 && wdt1.size() > 0) begin t = wdt1.pop_front(); return; end
      @(negedge clk);
    end
    chk("wr_timeout", LW'(0), LW'(1));
  endtask

  function automatic logic [LW-1:0] lat(input time t, input time ta);
    return LW'((t - ta - 5) / 10);
  endfunction

  initial begin
    time ta, tb, t;
    logic [AW-1:0] a;
    v0 = 0; v1 = 0; req_write = 0; req_addr = '0; req_be = '0; req_wd = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Reset values.
    chk("rst_ready", LW'(rdy0), LW'(1));
    chk("rst_rsp_valid", LW'(rv0), LW'(0));
    chk("rst_rsp_rd", rd0, '0);
    chk("rst_wr_done", LW'(wdn0), LW'(0));
    chk("rst_err", LW'(er0), LW'(0));
    rst = 1'b0;

    // Full write then read of 0x10.
    issue(0, 1, AW'(32'h10), '1, rnd_line(), ta);
    get_wr(0, t);
    chk("wr_lat", lat(t, ta), LW'(2));
    repeat (3) @(negedge clk);
    chk("wr_done_pulse", LW'(wdt0.size()), LW'(0));
    issue(0, 0, AW'(32'h10), '0, '0, ta);
    get_rsp(0, "rd_full", t);
    chk("rd_lat", lat(t, ta), LW'(3));
    repeat (3) @(negedge clk);
    chk("rsp_one_cycle", LW'(got0.size()), LW'(0));

    // Partial write over low four bytes.
    issue(0, 1, AW'(32'h10), LB'(32'h0000_000F), rnd_line(), ta);
    get_wr(0, t);
    issue(0, 0, AW'(32'h10), '0, '0, ta);
    get_rsp(0, "rd_partial", t);

    // Random full + partial writes, each read back.
    for (int i = 0; i < 6; i++) begin
      a = AW'(32'h100 + $urandom_range(0, 15));
      issue(0, 1, a, '1, rnd_line(), ta);
      issue(0, 1, a, LB'($urandom), rnd_line(), ta);
      issue(0, 0, a, '0, '0, ta);
      get_wr(0, t); get_wr(0, t);
      get_rsp(0, "rd_random", t);
    end

    // Backpressure: 4 queued + 1 in flight fills the port.
    for (int i = 0; i < 6; i++) begin
      issue(0, 1, AW'(32'h20 + i), '1, rnd_line(), ta);
      get_wr(0, t);
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(0, 0, AW'(32'h20 + i), '0, '0, ta);
    @(negedge clk);
    chk("full_ready_low", LW'(rdy0), LW'(0));
    req_write = 0; req_addr = AW'(32'h25); v0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_valid", LW'(rv0), LW'(1));
      chk("held_data", rd0, exp0[0]);
    end
    exp0.push_back(refm[m_key(0, AW'(32'h25))]);
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !rdy0; i++) @(negedge clk);
    chk("sixth_accept", LW'(rdy0), LW'(1));
    @(posedge clk); #1 v0 = 1'b0;
    for (int i = 0; i < 6; i++) get_rsp(0, "drain_order", t);

    // Slow instance: single-op latencies, then interleaved order.
    issue(1, 1, AW'(32'h40), '1, rnd_line(), ta);
    get_wr(1, t);
    chk("slow_wr_lat", lat(t, ta), LW'(4));
    issue(1, 0, AW'(32'h40), '0, '0, ta);
    get_rsp(1, "slow_rd", t);
    chk("slow_rd_lat", lat(t, ta), LW'(6));
    repeat (3) @(negedge clk);
    ev1 = {};
    issue(1, 1, AW'(32'h41), '1, rnd_line(), ta);
    issue(1, 0, AW'(32'h41), '0, '0, ta);
    issue(1, 1, AW'(32'h41), LB'($urandom), rnd_line(), ta);
    issue(1, 0, AW'(32'h41), '0, '0, ta);
    for (int i = 0; i < 100 && ev1.size() < 4; i++) @(negedge clk);
    chk("alt_count", LW'(ev1.size()), LW'(4));
    for (int i = 0; i < 4 && i < ev1.size(); i++)
      chk("alt_order", LW'(ev1[i]), LW'((i % 2) + 1));
    get_rsp(1, "alt_rd", t);
    get_rsp(1, "alt_rd", t);
    wdt1 = {};

    // Reset while a read is in RD_WAIT.
    issue(0, 1, AW'(32'h30), '1, rnd_line(), ta);
    get_wr(0, t);
    issue(0, 0, AW'(32'h30), '0, '0, ta);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    void'(exp0.pop_back());
    @(negedge clk);
    chk("mid_rst_ready", LW'(rdy0), LW'(1));
    chk("mid_rst_valid", LW'(rv0), LW'(0));
    chk("mid_rst_rd", rd0, '0);
    chk("mid_rst_wr_done", LW'(wdn0), LW'(0));
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_rsp", LW'(got0.size()), LW'(0));
    issue(0, 0, AW'(32'h30), '0, '0, ta);
    get_rsp(0, "rd_after_rst", t);

    // Out-of-range accesses (flagged or wrapped depending on build).
    issue(0, 1, AW'(0), '1, rnd_line(), ta);
    issue(0, 1, AW'(1), '1, rnd_line(), ta);
    get_wr(0, t); get_wr(0, t);
    errcnt0 = 0;
    issue(0, 0, AW'(ENT), '0, '0, ta);
    get_rsp(0, "oob_read", tb);
    issue(0, 1, AW'(ENT + 1), '1, rnd_line(), ta);
    get_wr(0, t);
    issue(0, 0, AW'(1), '0, '0, ta);
    get_rsp(0, "oob_line1", t);
    issue(0, 0, AW'(0), '0, '0, ta);
    get_rsp(0, "oob_line0", t);
`ifdef MAINMEM_BOUNDS_CHECK_EN
    chk("err_pulses", LW'(errcnt0), LW'(2));
`else
    chk("err_tied", LW'(errcnt0), LW'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
